// File: rtl/irq_ctrl_prio_pkg.sv
// Shared types and constants for the prioritised
// sub-CPU interrupt controller.
package mcd_irq_pkg;

  typedef enum logic {
    IRQ_EDGE  = 1'b0,
    IRQ_LEVEL = 1'b1
  } irq_mode_t;

  localparam logic [1:0] FC_CPU_SPACE = 2'b11;
  localparam logic [2:0] IPL_NONE     = 3'b111;

endpackage

// File: rtl/irq_ctrl_prio_if.sv
// 68000 interrupt bus between the sub-CPU (master)
// and the interrupt controller (slave).
interface irq_ctrl_prio_if;

  logic [2:0] cpu_fc;
  logic [2:0] cpu_addr;
  logic       cpu_oe;
  logic [2:0] cpu_ipl;
  logic       cpu_vpa;

  modport master (
    output cpu_fc,
    output cpu_addr,
    output cpu_oe,
    input  cpu_ipl,
    input  cpu_vpa
  );

  modport slave (
    input  cpu_fc,
    input  cpu_addr,
    input  cpu_oe,
    output cpu_ipl,
    output cpu_vpa
  );

endinterface

// File: rtl/irq_ctrl_prio_chan.sv
// One request channel: input sync, rising-edge
// detect, pending and sticky overflow flags.
module irq_prio_chan
  import mcd_irq_pkg::*;
(
  input  logic      clk_asic,
  input  logic      rst,
  input  logic      req,
  input  irq_mode_t mode,
  input  logic      ack_sel,
  input  logic      clr,
  output logic      pend,
  output logic      ovf
);

  // hist[0] syncs, hist[2:1] is the edge history
  logic [2:0] hist;
  logic       edge_det;

  assign edge_det = hist[1] & ~hist[2];

  always_ff @(posedge clk_asic) begin
    if (rst) begin
      hist <= '0;
      pend <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      hist <= {hist[1:0], req};
      if (clr)
        ovf <= 1'b0;
      else if (mode == IRQ_EDGE && edge_det &&
               pend && !ack_sel)
        ovf <= 1'b1;
      // a new edge wins over ack and clear
      if (mode == IRQ_LEVEL)
        pend <= req;
      else if (edge_det)
        pend <= 1'b1;
      else if (ack_sel || clr)
        pend <= 1'b0;
    end
  end

endmodule

// File: rtl/irq_ctrl_prio.sv
// Prioritised 68000 interrupt controller: level
// reduction, IACK channel select, IPL/VPA drive.
module irq_ctrl_prio
  import mcd_irq_pkg::*;
#(
  parameter int N_CH  = 6,
  parameter int LVL_W = 3
) (
  input  logic              clk_asic,
  input  logic              rst,
  input  logic              sub_sync,
  input  logic [N_CH-1:0]   ireq,
  input  logic [N_CH-1:0]   imsk,
  input  logic [N_CH-1:0]   imode,
  input  logic [N_CH*LVL_W-1:0] ilvl,
  input  logic              clr_stb,
  input  logic [N_CH-1:0]   clr_mask,
  irq_ctrl_prio_if.slave    bus,
  output logic [N_CH-1:0]   irq_pend_out,
  output logic [N_CH-1:0]   irq_ovf_out
);

  logic [LVL_W-1:0] lvl [N_CH];
  logic [LVL_W-1:0] max_lvl;
  logic [N_CH-1:0]  ack_sel;
  logic             iack;
  logic             idle_q;
  logic             ack_start;

  assign iack = !bus.cpu_oe &&
                bus.cpu_fc[1:0] == FC_CPU_SPACE;

  // idle_q resets low so an IACK already active
  // at reset release is never acknowledged
  assign ack_start = iack & idle_q;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    assign lvl[k] = ilvl[k*LVL_W +: LVL_W];
    irq_prio_chan u_chan (
      .clk_asic (clk_asic),
      .rst      (rst),
      .req      (ireq[k] & imsk[k]),
      .mode     (irq_mode_t'(imode[k])),
      .ack_sel  (ack_sel[k]),
      .clr      (clr_stb & clr_mask[k]),
      .pend     (irq_pend_out[k]),
      .ovf      (irq_ovf_out[k])
    );
  end

  always_comb begin
    max_lvl = '0;
    for (int k = 0; k < N_CH; k++)
      if (irq_pend_out[k] && lvl[k] > max_lvl)
        max_lvl = lvl[k];
  end

  // ascending scan: highest matching index wins
  always_comb begin
    ack_sel = '0;
    for (int k = 0; k < N_CH; k++)
      if (ack_start && irq_pend_out[k] &&
          imode[k] == IRQ_EDGE && |lvl[k] &&
          lvl[k] == bus.cpu_addr) begin
        ack_sel    = '0;
        ack_sel[k] = 1'b1;
      end
  end

  always_ff @(posedge clk_asic) begin
    if (rst) begin
      idle_q      <= 1'b0;
      bus.cpu_ipl <= IPL_NONE;
      bus.cpu_vpa <= 1'b1;
    end else begin
      idle_q <= !iack;
      if (sub_sync) begin
        bus.cpu_ipl <= ~max_lvl;
        bus.cpu_vpa <= !iack;
      end
    end
  end

endmodule

// File: tb/tb_irq_ctrl_prio.sv
// Directed plus randomized bench for irq_ctrl_prio
// against a behavioural model.
module tb_irq_ctrl_prio;

  localparam int N = 6;

  logic           clk_asic = 1'b0;
  logic           rst;
  logic           sub_sync;
  logic [N-1:0]   ireq, imsk, imode, clr_mask;
  logic [3*N-1:0] ilvl;
  logic           clr_stb;
  logic [N-1:0]   pend, ovf;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  irq_ctrl_prio_if bus_if ();

  irq_ctrl_prio #(.N_CH(N), .LVL_W(3)) dut (
    .clk_asic     (clk_asic),
    .rst          (rst),
    .sub_sync     (sub_sync),
    .ireq         (ireq),
    .imsk         (imsk),
    .imode        (imode),
    .ilvl         (ilvl),
    .clr_stb      (clr_stb),
    .clr_mask     (clr_mask),
    .bus          (bus_if),
    .irq_pend_out (pend),
    .irq_ovf_out  (ovf)
  );

  always #5 clk_asic = ~clk_asic;

  // behavioural model state
  logic [N-1:0] m_pend, m_ovf;
  logic [N-1:0] r1, r2, r3;
  logic [2:0]   m_ipl;
  logic         m_vpa;
  logic         m_idle;

  function automatic int lvl_of(int k);
    logic [2:0] v;
    v = ilvl[3*k +: 3];
    return int'(v);
  endfunction

  always @(posedge clk_asic) begin
    int mx, ak;
    bit iq, e, c;
    if (rst) begin
      m_pend = '0; m_ovf = '0;
      r1 = '0; r2 = '0; r3 = '0;
      m_ipl = 3'b111; m_vpa = 1'b1;
      m_idle = 1'b0;
    end else begin
      iq = !bus_if.cpu_oe &&
           bus_if.cpu_fc[1:0] == 2'b11;
      mx = 0;
      for (int k = 0; k < N; k++)
        if (m_pend[k] && lvl_of(k) > mx)
          mx = lvl_of(k);
      ak = -1;
      if (iq && m_idle)
        for (int k = N-1; k >= 0; k--)
          if (ak < 0 && m_pend[k] && !imode[k] &&
              lvl_of(k) != 0 &&
              lvl_of(k) == int'(bus_if.cpu_addr))
            ak = k;
      for (int k = 0; k < N; k++) begin
        e = r2[k] && !r3[k];
        c = clr_stb && clr_mask[k];
        if (c) m_ovf[k] = 1'b0;
        if (imode[k])
          m_pend[k] = ireq[k] & imsk[k];
        else if (e) begin
          if (m_pend[k] && ak != k && !c)
            m_ovf[k] = 1'b1;
          m_pend[k] = 1'b1;
        end else if (ak == k || c)
          m_pend[k] = 1'b0;
      end
      r3 = r2; r2 = r1; r1 = ireq & imsk;
      if (sub_sync) begin
        m_ipl = ~mx[2:0];
        m_vpa = !iq;
      end
      m_idle = !iq;
    end
  end

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  always @(negedge clk_asic) begin
    if (chk_en) begin
      chk("ipl", 32'(bus_if.cpu_ipl), 32'(m_ipl));
      chk("vpa", 32'(bus_if.cpu_vpa), 32'(m_vpa));
      chk("pend", 32'(pend), 32'(m_pend));
      chk("ovf", 32'(ovf), 32'(m_ovf));
    end
  end

  task automatic tick(int n = 1);
    repeat (n) @(posedge clk_asic);
    #2;
  endtask

  task automatic idle_bus();
    bus_if.cpu_oe   = 1'b1;
    bus_if.cpu_fc   = 3'b101;
    bus_if.cpu_addr = 3'd0;
  endtask

  task automatic iack_on(logic [2:0] a);
    bus_if.cpu_fc   = 3'b111;
    bus_if.cpu_addr = a;
    bus_if.cpu_oe   = 1'b0;
  endtask

  task automatic set_lvl(int k, logic [2:0] v);
    ilvl[3*k +: 3] = v;
  endtask

  task automatic clear_all();
    ireq = '0;
    tick(4);
    clr_stb = 1'b1; clr_mask = '1;
    tick(1);
    clr_stb = 1'b0; clr_mask = '0;
    tick(2);
  endtask

  initial begin
    rst = 1'b1; sub_sync = 1'b1;
    ireq = '0; imsk = '1; imode = '0; ilvl = '0;
    clr_stb = 1'b0; clr_mask = '0;
    idle_bus();
    tick(2);
    chk("rst_ipl", 32'(bus_if.cpu_ipl), 32'h7);
    chk("rst_vpa", 32'(bus_if.cpu_vpa), 32'h1);
    chk("rst_pend", 32'(pend), 32'h0);
    chk("rst_ovf", 32'(ovf), 32'h0);
    chk_en = 1'b1;
    rst = 1'b0;
    tick(1);

    // single edge channel, level 2
    set_lvl(2, 3'd2);
    ireq[2] = 1'b1; tick(1); ireq[2] = 1'b0;
    tick(1);
    chk("t1_pend_early", 32'(pend), 32'h0);
    tick(1);
    chk("t1_pend", 32'(pend), 32'b000100);
    chk("t1_model_pend", 32'(m_pend), 32'b000100);
    tick(1);
    chk("t1_ipl", 32'(bus_if.cpu_ipl), 32'b101);
    iack_on(3'd2); tick(1);
    chk("t1_vpa", 32'(bus_if.cpu_vpa), 32'h0);
    chk("t1_acked", 32'(pend), 32'h0);
    tick(1);
    chk("t1_ipl_idle", 32'(bus_if.cpu_ipl), 32'b111);
    idle_bus(); tick(1);

    // priority between two levels
    set_lvl(1, 3'd5); set_lvl(4, 3'd3);
    ireq = 6'b010010; tick(1); ireq = '0;
    tick(3);
    chk("t2_pend", 32'(pend), 32'b010010);
    chk("t2_ipl", 32'(bus_if.cpu_ipl), 32'b010);
    iack_on(3'd5); tick(1);
    chk("t2_ack_ch1", 32'(pend), 32'b010000);
    tick(1);
    chk("t2_ipl_lo", 32'(bus_if.cpu_ipl), 32'b100);
    chk("t2_model_ipl", 32'(m_ipl), 32'b100);
    idle_bus(); clear_all();

    // same level: highest index first, one per IACK
    set_lvl(3, 3'd4); set_lvl(5, 3'd4);
    ireq = 6'b101000; tick(1); ireq = '0;
    tick(3);
    chk("t3_pend", 32'(pend), 32'b101000);
    iack_on(3'd4); tick(1);
    chk("t3_ack_ch5", 32'(pend), 32'b001000);
    tick(19);
    chk("t3_long_iack", 32'(pend), 32'b001000);
    idle_bus(); tick(1);
    iack_on(3'd4); tick(1);
    chk("t3_ack_ch3", 32'(pend), 32'h0);
    idle_bus(); tick(1);

    // overflow and software clear
    set_lvl(0, 3'd1);
    ireq[0] = 1'b1; tick(1); ireq[0] = 1'b0;
    tick(2);
    chk("t4_pend", 32'(pend), 32'b000001);
    ireq[0] = 1'b1; tick(1); ireq[0] = 1'b0;
    tick(2);
    chk("t4_ovf", 32'(ovf), 32'b000001);
    chk("t4_model_ovf", 32'(m_ovf), 32'b000001);
    clr_stb = 1'b1; clr_mask = 6'b000001;
    tick(1);
    clr_stb = 1'b0;
    chk("t4_clr_pend", 32'(pend), 32'h0);
    chk("t4_clr_ovf", 32'(ovf), 32'h0);
    ireq[0] = 1'b1; tick(1); ireq[0] = 1'b0;
    tick(1);
    clr_stb = 1'b1; tick(1); clr_stb = 1'b0;
    chk("t4_edge_wins", 32'(pend), 32'b000001);
    chk("t4_no_ovf", 32'(ovf), 32'h0);
    clear_all();

    // level-mode channel ignores ack
    imode[5] = 1'b1; set_lvl(5, 3'd6);
    ireq[5] = 1'b1; tick(2);
    chk("t5_pend", 32'(pend), 32'b100000);
    chk("t5_ipl", 32'(bus_if.cpu_ipl), 32'b001);
    iack_on(3'd6); tick(1);
    chk("t5_vpa", 32'(bus_if.cpu_vpa), 32'h0);
    chk("t5_no_ack", 32'(pend), 32'b100000);
    idle_bus(); ireq[5] = 1'b0;
    tick(2);
    chk("t5_drop_ipl", 32'(bus_if.cpu_ipl), 32'b111);
    chk("t5_drop_pend", 32'(pend), 32'h0);
    imode = '0; tick(4);

    // IPL holds while sub_sync is low
    sub_sync = 1'b0;
    ireq[2] = 1'b1; tick(1); ireq[2] = 1'b0;
    tick(4);
    chk("t6_pend", 32'(pend), 32'b000100);
    chk("t6_hold", 32'(bus_if.cpu_ipl), 32'b111);
    sub_sync = 1'b1; tick(1);
    chk("t6_update", 32'(bus_if.cpu_ipl), 32'b101);
    clear_all();

    // reset during IACK, IACK held across release
    for (int k = 0; k < N; k++)
      set_lvl(k, 3'(k + 1));
    ireq = '1; tick(1); ireq = '0;
    tick(3);
    chk("t7_pend_all", 32'(pend), 32'b111111);
    iack_on(3'd3); rst = 1'b1;
    tick(1);
    chk("t7_rst_ipl", 32'(bus_if.cpu_ipl), 32'h7);
    chk("t7_rst_vpa", 32'(bus_if.cpu_vpa), 32'h1);
    chk("t7_rst_pend", 32'(pend), 32'h0);
    chk("t7_rst_ovf", 32'(ovf), 32'h0);
    rst = 1'b0;
    ireq = '1; tick(1); ireq = '0;
    tick(6);
    chk("t7_no_ack", 32'(pend), 32'b111111);
    idle_bus(); clear_all();

    // randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      for (int k = 0; k < N; k++)
        if ($urandom_range(0, 7) == 0)
          ireq[k] = ~ireq[k];
      if ($urandom_range(0, 99) == 0)
        imsk = 6'($urandom);
      if ($urandom_range(0, 199) == 0)
        imode = 6'($urandom);
      if ($urandom_range(0, 49) == 0)
        set_lvl(int'($urandom_range(0, N-1)),
                3'($urandom));
      if (bus_if.cpu_oe) begin
        if ($urandom_range(0, 5) == 0) begin
          bus_if.cpu_fc = ($urandom_range(0, 3) == 0)
                          ? 3'b101 : 3'b111;
          bus_if.cpu_addr = 3'($urandom);
          bus_if.cpu_oe = 1'b0;
        end
      end else if ($urandom_range(0, 3) == 0)
        idle_bus();
      clr_stb  = ($urandom_range(0, 29) == 0);
      clr_mask = 6'($urandom);
      sub_sync = 1'($urandom);
      rst      = ($urandom_range(0, 699) == 0);
      tick(1);
    end
    rst = 1'b0;
    tick(2);

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule

// File: doc/irq_ctrl_prio.md
Name: irq_ctrl_prio

Overview:
- Parametrised successor to the sub-CPU interrupt controller in lib_mcd.
- Takes N_CH interrupt request lines and gives each channel a programmable mask, edge/level mode and IPL level (0-7).
- Drives the 68000 IPL and VPA (autovector) pins and tracks pending and overflow status per channel.
- Acknowledges exactly one channel per IACK bus cycle; software can clear pending bits by mask.

Parameters:
N_CH, 6, number of request channels (1..16)
LVL_W, 3, width of a per-channel level field (fixed 3, matches 68000 IPL)

Ports:
clk_asic  in  1  ASIC clock
rst  in  1  synchronous, active-high reset on clk_asic
sub_sync  in  1  sub-CPU bus-phase enable; IPL/VPA update only when high
ireq  in  N_CH  raw request lines, asynchronous to CPU bus
imsk  in  N_CH  per-channel enable; 1 = enabled
imode  in  N_CH  per-channel mode; 0 = edge (latched), 1 = level
ilvl  in  N_CH*3  per-channel IPL level, channel k at [3k+2:3k]; 0 = never interrupts
cpu_fc  in  3  68000 function code
cpu_addr  in  3  68000 A[3:1]
cpu_oe  in  1  bus read strobe, active low
clr_stb  in  1  one-clock software clear strobe
clr_mask  in  N_CH  channels to clear when clr_stb = 1
cpu_ipl  out  3  68000 IPL[2:0], active low
cpu_vpa  out  1  autovector request, active low
irq_pend_out  out  N_CH  pending status
irq_ovf_out  out  N_CH  sticky overflow: an edge arrived while already pending

Behaviour:
- Reset values: cpu_ipl = 3'b111, cpu_vpa = 1, all pending = 0, all ovf = 0, sync/edge/ack history = 0.
- Request path, every clk_asic cycle (not gated by sub_sync):
  - 2-flop history on ireq & imsk; edge = history 01.
  - Edge mode: pend sets on edge. If pend is already 1 and no ack/clear occurs that cycle, ovf sets.
  - Level mode: pend = registered (ireq & imsk), one cycle latency. Ack and clear have no effect.
  - ovf clears only via clr_stb on that channel, or by rst.
- Effective level per channel: ilvl[k] if pend[k], else 0. max_lvl = maximum effective level over all channels.
- IACK detection:
  - iack = !cpu_oe & cpu_fc[1:0] == 2'b11.
  - ack_start = rising edge of iack, sampled on clk_asic. Acknowledge fires only on ack_start, once per bus cycle, so edges arriving during the rest of a long IACK cycle are never lost.
  - On ack_start, the acked channel is the highest-index edge-mode pending channel with ilvl == cpu_addr; its pend clears next cycle.
  - No match (spurious level, or level-mode source): no state change.
- Simultaneous events on one channel in the same cycle: new edge beats ack, and new edge beats clr_stb; pend stays 1 and ovf does not set.
- When sub_sync = 1, registered outputs update:
  - cpu_ipl <= ~max_lvl.
  - cpu_vpa <= !iack.
  - When sub_sync = 0 both hold their value.
- Latency: edge on ireq to pend = 3 clk_asic; pend to cpu_ipl = next sub_sync cycle.
- Level-0 channels can pend and overflow but never drive IPL and are never acked.
- Level 7 is passed through unchanged; the 68000 treats it as NMI.
- Reset mid-IACK: all state clears. ack_start is not generated for an IACK already low at reset release, because history resets to 0 and needs the 0→1 transition.
- Changing ilvl while a channel is pending takes effect on the next cycle's max_lvl.

Decomposition:
- Package mcd_irq_pkg holds:
  - typedef irq_mode_t {IRQ_EDGE = 0, IRQ_LEVEL = 1};
  - FC_CPU_SPACE = 2'b11;
  - IPL_NONE = 3'b111.
- Sub-module irq_prio_chan, one per channel: sync/edge detector, pend/ovf flops, inputs ack_sel and clr.
- The top level holds the max-level reduction, the ack channel selector and the IPL/VPA registers.

Test Plan:
- N_CH=6, ch2 edge, lvl 2, masked on: pulse ireq[2]. Expect pend[2] = 1 after 3 clk and cpu_ipl = 3'b101 on next sub_sync. IACK with addr = 2 gives vpa = 0, then pend[2] = 0 and ipl = 3'b111.
- Ch1 lvl 5 and ch4 lvl 3 both pending: ipl = 3'b010. Ack addr = 5 clears only ch1, then ipl = 3'b100.
- Ch3 and ch5 both lvl 4, both pending: ack addr = 4 clears ch5 only. A second IACK cycle clears ch3. Holding one IACK low for 20 clk clears only one channel.
- Ch0 edge: two edges without an ack give ovf[0] = 1. clr_stb with clr_mask = 6'b000001 clears pend[0] and ovf[0]. An edge in the same cycle as clr_stb leaves pend[0] = 1.
- Ch6-of-6 (index 5) level mode, lvl 6: hold ireq high, ipl = 3'b001. Ack addr = 6 leaves pend set. Dropping ireq gives ipl = 3'b111 by the second sub_sync.
- Assert rst during IACK with pend = 6'b111111: all outputs return to reset values next clk. Keeping cpu_oe low after release gives no ack.
